prime_search_engine: RTL and testbench

PRIME_SEARCH_ENGINE -- requirements
Module: prime_search_engine

---
 rtl/prime_search_engine.sv | 152 +++++++++++++++
 tb/tb_prime_search_engine.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/prime_search_engine.sv
// prime_search_engine: finds the largest prime below a latched limit
// by odd trial division with a bit-serial restoring remainder.
module prime_search_engine #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] PrimeSearchLimit,
  input  logic             CounterBlockEnable,
  output logic [WIDTH-1:0] LargestPrime,
  output logic             Complete,
  output logic             Busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAND,
    DIVINIT,
    DIV,
    TEST,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] div_d;
  logic [WIDTH-1:0] rem;
  logic [WIDTH+1:0] sq;
  logic [IW-1:0]    bit_idx;

  logic             cand_bit;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;

  // one restoring-division step on the current candidate bit
  always_comb begin
    cand_bit = cand[bit_idx];
    rem_sh   = {rem, cand_bit};
    rem_sub  = rem_sh - {1'b0, div_d};
    rem_ge   = (rem_sh >= {1'b0, div_d});
  end

  // search FSM; all outputs registered
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state        <= IDLE;
      limit_q      <= '0;
      cand         <= '0;
      div_d        <= '0;
      rem          <= '0;
      sq           <= '0;
      bit_idx      <= '0;
      LargestPrime <= '0;
      Complete     <= 1'b0;
      Busy         <= 1'b0;
    end else if (Busy && !CounterBlockEnable) begin
      state <= IDLE;
      Busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          Complete <= 1'b0;
          if (CounterBlockEnable) begin
            limit_q <= PrimeSearchLimit;
            state   <= LOAD;
            Busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (limit_q <= WIDTH'(2)) begin
            LargestPrime <= '0;
            Complete     <= 1'b1;
            Busy         <= 1'b0;
            state        <= DONE;
          end else begin
            cand  <= limit_q - WIDTH'(1);
            state <= CAND;
          end
        end
        CAND: begin
          if (cand < WIDTH'(2)) begin
            LargestPrime <= '0;
            Complete     <= 1'b1;
            Busy         <= 1'b0;
            state        <= DONE;
          end else if (cand == WIDTH'(2) ||
                       cand == WIDTH'(3)) begin
            LargestPrime <= cand;
            Complete     <= 1'b1;
            Busy         <= 1'b0;
            state        <= DONE;
          end else if (!cand[0]) begin
            cand <= cand - WIDTH'(1);
          end else begin
            div_d <= WIDTH'(3);
            sq    <= (WIDTH+2)'(9);
            state <= DIVINIT;
          end
        end
        DIVINIT: begin
          if (sq > {2'b00, cand}) begin
            LargestPrime <= cand;
            Complete     <= 1'b1;
            Busy         <= 1'b0;
            state        <= DONE;
          end else begin
            rem     <= '0;
            bit_idx <= IW'(WIDTH - 1);
            state   <= DIV;
          end
        end
        DIV: begin
          rem <= rem_ge ? rem_sub[WIDTH-1:0]
                        : rem_sh[WIDTH-1:0];
          if (bit_idx == '0) begin
            state <= TEST;
          end else begin
            bit_idx <= bit_idx - IW'(1);
          end
        end
        TEST: begin
          if (rem == '0) begin
            cand  <= cand - WIDTH'(2);
            state <= CAND;
          end else begin
            div_d <= div_d + WIDTH'(2);
            sq    <= sq + {div_d, 2'b00}
                        + (WIDTH+2)'(4);
            state <= DIVINIT;
          end
        end
        DONE: begin
          if (!CounterBlockEnable) begin
            Complete <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          Busy     <= 1'b0;
          Complete <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_search_engine.sv
// tb_prime_search_engine: directed vectors plus a few
// random limits checked against a trial-division model.
module tb_prime_search_engine;

  localparam int W = 20;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] lim;
  logic         en;
  logic [W-1:0] lp;
  logic         done;
  logic         busy;

  int n_cmp;
  int n_err;

  prime_search_engine #(.WIDTH(W)) dut (
    .clk               (clk),
    .Reset_n           (rst_n),
    .PrimeSearchLimit  (lim),
    .CounterBlockEnable(en),
    .LargestPrime      (lp),
    .Complete          (done),
    .Busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++)
      if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int ref_prime(input int l);
    for (int c = l - 1; c >= 2; c--)
      if (is_prime(c)) return c;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_search(input string tag,
                            input int lim_v,
                            input int exp_v,
                            input int budget);
    bit seen;
    tick();
    lim = lim_v[W-1:0];
    en  = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_lp"}, 32'(lp), 32'(exp_v));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_hold"}, 32'(done), 32'd1);
    end
    en = 1'b0;
    tick();
    check({tag, "_drop"}, 32'(done), 32'd0);
    check({tag, "_keep"}, 32'(lp), 32'(exp_v));
  endtask

  initial begin
    int rl;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    lim   = '0;
    repeat (3) tick();
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lp", 32'(lp), 32'd0);
    rst_n = 1'b1;

    run_search("l100", 100, 97, 5000);
    run_search("l0", 0, 0, 100);
    run_search("l1", 1, 0, 100);
    run_search("l2", 2, 0, 100);
    run_search("l3", 3, 2, 100);
    run_search("l4", 4, 3, 100);
    run_search("l10", 10, 7, 500);
    run_search("l25", 25, 23, 500);
    run_search("l1m", 1000000, 999983, 50000);

    run_search("pre", 25, 23, 500);
    tick();
    lim = 20'd1000000;
    en  = 1'b1;
    repeat (100) tick();
    check("abort_busy", 32'(busy), 32'd1);
    en = 1'b0;
    tick();
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_lp", 32'(lp), 32'd23);
    run_search("rereq", 100, 97, 5000);

    run_search("pre2", 10, 7, 500);
    tick();
    lim = 20'd100;
    en  = 1'b1;
    repeat (5) tick();
    lim = 20'd50;
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 5000 && !seen; n++) begin
        tick();
        if (done) seen = 1'b1;
      end
      check("chg_done", 32'(seen), 32'd1);
      check("chg_lp", 32'(lp), 32'd97);
    end
    en = 1'b0;
    tick();

    tick();
    lim = 20'd1000000;
    en  = 1'b1;
    repeat (30) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    en    = 1'b0;
    tick();
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_lp", 32'(lp), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      rl = int'($urandom_range(65535, 2));
      run_search("rand16", rl, ref_prime(rl), 20000);
    end
    rl = int'($urandom_range(1048575, 65536));
    run_search("rand20", rl, ref_prime(rl), 40000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
